// File: rtl/jellyvl_etherneco_pkg.sv
// Shared definitions for the Etherneco slave router: header layout and FSM states.
package jellyvl_etherneco_pkg;

    // The header is four bytes: length low, length high, type, node.
    localparam int HDR_LEN   = 4;
    localparam int HDR_CNT_W = $clog2(HDR_LEN);

    localparam logic [HDR_CNT_W-1:0] HDR_OFS_LEN_LO = 2'd0;
    localparam logic [HDR_CNT_W-1:0] HDR_OFS_LEN_HI = 2'd1;
    localparam logic [HDR_CNT_W-1:0] HDR_OFS_TYPE   = 2'd2;
    localparam logic [HDR_CNT_W-1:0] HDR_OFS_NODE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/jellyvl_etherneco_func_mux.sv
// Function channel decode: turns the frame type into a one-hot payload strobe
// and picks the substitution byte of the selected channel.
module jellyvl_etherneco_func_mux #(
    parameter int         FUNC_NUM  = 2,
    parameter logic [7:0] TYPE_BASE = 8'h10
) (
    input  logic [7:0]            type_i,
    input  logic                  active_i,
    input  logic [FUNC_NUM-1:0]   replace_valid_i,
    input  logic [8*FUNC_NUM-1:0] replace_data_i,
    output logic [FUNC_NUM-1:0]   payload_valid_o,
    output logic                  replace_hit_o,
    output logic [7:0]            replace_data_o
);

    logic [7:0] sel;
    assign sel = type_i - TYPE_BASE;

    // At most one channel matches; types below TYPE_BASE wrap to large values and match none.
    always_comb begin
        payload_valid_o = '0;
        replace_hit_o   = 1'b0;
        replace_data_o  = 8'h00;
        for (int i = 0; i < FUNC_NUM; i++) begin
            if (active_i && (sel == 8'(i))) begin
                payload_valid_o[i] = 1'b1;
                if (replace_valid_i[i]) begin
                    replace_hit_o  = 1'b1;
                    replace_data_o = replace_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/jellyvl_etherneco_slave_router.sv
// Etherneco slave router: forwards the byte stream one cycle late, bumps the
// node byte, exposes the payload to function channels and lets them replace bytes.
// Optional build macro JELLYVL_ETHERNECO_ROUTER_STATS_EN adds saturating
// frame/error counters (stat_frames, stat_errors).
//
// Streams are valid-only: a byte is transferred on every clk edge where valid is
// high; there is no ready/backpressure, so the router must accept every byte.
module jellyvl_etherneco_slave_router
    import jellyvl_etherneco_pkg::*;
#(
    parameter int          FUNC_NUM    = 2,
    parameter logic [7:0]  TYPE_BASE   = 8'h10,
    parameter bit          DOWN_STREAM = 1'b0,
    parameter logic [15:0] MAX_LENGTH  = 16'd1500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_rx_first,
    input  logic                  s_rx_last,
    input  logic                  s_rx_valid,
    input  logic [7:0]            s_rx_data,
    output logic                  m_tx_first,
    output logic                  m_tx_last,
    output logic                  m_tx_valid,
    output logic [7:0]            m_tx_data,
    output logic                  rx_start,
    output logic                  rx_end,
    output logic                  rx_error,
    output logic [15:0]           rx_length,
    output logic [7:0]            rx_type,
    output logic [7:0]            rx_node,
    output logic                  payload_first,
    output logic                  payload_last,
    output logic [15:0]           payload_pos,
    output logic [7:0]            payload_data,
    output logic [FUNC_NUM-1:0]   payload_valid,
    input  logic [8*FUNC_NUM-1:0] replace_data,
    input  logic [FUNC_NUM-1:0]   replace_valid,
`ifdef JELLYVL_ETHERNECO_ROUTER_STATS_EN
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_errors,
`endif
    output logic [1:0]            dbg_state_o
);

    state_t                 state_q, state_d;
    logic [HDR_CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [15:0]            hdr_len_q, hdr_len_d;
    logic [7:0]             hdr_type_q, hdr_type_d;
    logic [15:0]            pos_q, pos_d;
    logic [15:0]            rx_length_q, rx_length_d;
    logic [7:0]             rx_type_q, rx_type_d;
    logic [7:0]             rx_node_q, rx_node_d;
    logic                   rx_start_q, rx_start_d;
    logic                   rx_end_q, rx_end_d;
    logic                   rx_error_q, rx_error_d;
    logic                   tx_first_q, tx_last_q, tx_valid_q;
    logic [7:0]             tx_data_q, tx_data_d;

    logic                   active;
    logic                   node_byte;
    logic                   repl_hit;
    logic [7:0]             repl_data;

    assign active    = (state_q == ST_PAYLOAD) && s_rx_valid && !s_rx_first;
    assign node_byte = (state_q == ST_HEADER) && s_rx_valid && !s_rx_first
                       && (hdr_cnt_q == HDR_OFS_NODE);

    jellyvl_etherneco_func_mux #(
        .FUNC_NUM  (FUNC_NUM),
        .TYPE_BASE (TYPE_BASE)
    ) u_func_mux (
        .type_i          (rx_type_q),
        .active_i        (active),
        .replace_valid_i (replace_valid),
        .replace_data_i  (replace_data),
        .payload_valid_o (payload_valid),
        .replace_hit_o   (repl_hit),
        .replace_data_o  (repl_data)
    );

    // Frame parser: header capture, payload counting and end/error classification.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_len_d   = hdr_len_q;
        hdr_type_d  = hdr_type_q;
        pos_d       = pos_q;
        rx_length_d = rx_length_q;
        rx_type_d   = rx_type_q;
        rx_node_d   = rx_node_q;
        rx_start_d  = 1'b0;
        rx_end_d    = 1'b0;
        rx_error_d  = 1'b0;
        if (s_rx_valid) begin
            if (s_rx_first) begin
                // A new frame always wins; an unfinished frame is reported as broken.
                // DRAIN frames were already reported when their length was rejected.
                if ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD)) rx_error_d = 1'b1;
                hdr_len_d = {8'h00, s_rx_data};
                pos_d     = 16'd0;
                if (s_rx_last) begin
                    rx_error_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d   = ST_HEADER;
                    hdr_cnt_d = HDR_OFS_LEN_HI;
                end
            end else begin
                unique case (state_q)
                    ST_HEADER: begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == HDR_OFS_LEN_HI) hdr_len_d[15:8] = s_rx_data;
                        if (hdr_cnt_q == HDR_OFS_TYPE)   hdr_type_d      = s_rx_data;
                        if (s_rx_last) begin
                            rx_error_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else if (hdr_cnt_q == HDR_OFS_NODE) begin
                            rx_start_d  = 1'b1;
                            rx_length_d = hdr_len_q;
                            rx_type_d   = hdr_type_q;
                            rx_node_d   = s_rx_data;
                            pos_d       = 16'd0;
                            if (hdr_len_q > MAX_LENGTH) begin
                                rx_error_d = 1'b1;
                                state_d    = ST_DRAIN;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        // pos_q indexes the current byte; the frame carries length+1 bytes.
                        pos_d = pos_q + 16'd1;
                        if (s_rx_last) begin
                            if (pos_q == rx_length_q) rx_end_d   = 1'b1;
                            else                      rx_error_d = 1'b1;
                            state_d = ST_IDLE;
                        end else if (pos_q == rx_length_q) begin
                            rx_error_d = 1'b1;
                            state_d    = ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_rx_last) state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Forwarded byte: node gets stepped, a selected channel may overwrite payload.
    always_comb begin
        tx_data_d = s_rx_data;
        if (node_byte) begin
            tx_data_d = DOWN_STREAM ? (s_rx_data - 8'd1) : (s_rx_data + 8'd1);
        end else if (repl_hit) begin
            tx_data_d = repl_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= HDR_OFS_LEN_LO;
            hdr_len_q   <= 16'd0;
            hdr_type_q  <= 8'd0;
            pos_q       <= 16'd0;
            rx_length_q <= 16'd0;
            rx_type_q   <= 8'd0;
            rx_node_q   <= 8'd0;
            rx_start_q  <= 1'b0;
            rx_end_q    <= 1'b0;
            rx_error_q  <= 1'b0;
            tx_first_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_len_q   <= hdr_len_d;
            hdr_type_q  <= hdr_type_d;
            pos_q       <= pos_d;
            rx_length_q <= rx_length_d;
            rx_type_q   <= rx_type_d;
            rx_node_q   <= rx_node_d;
            rx_start_q  <= rx_start_d;
            rx_end_q    <= rx_end_d;
            rx_error_q  <= rx_error_d;
            tx_first_q  <= s_rx_first;
            tx_last_q   <= s_rx_last;
            tx_valid_q  <= s_rx_valid;
            tx_data_q   <= tx_data_d;
        end
    end

`ifdef JELLYVL_ETHERNECO_ROUTER_STATS_EN
    logic [31:0] stat_frames_q;
    logic [31:0] stat_errors_q;

    // Saturating counts of completed and failed frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_frames_q <= 32'd0;
            stat_errors_q <= 32'd0;
        end else begin
            if (rx_end_q   && (stat_frames_q != 32'hFFFF_FFFF)) stat_frames_q <= stat_frames_q + 32'd1;
            if (rx_error_q && (stat_errors_q != 32'hFFFF_FFFF)) stat_errors_q <= stat_errors_q + 32'd1;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_errors = stat_errors_q;
`endif

    assign m_tx_first    = tx_first_q;
    assign m_tx_last     = tx_last_q;
    assign m_tx_valid    = tx_valid_q;
    assign m_tx_data     = tx_data_q;
    assign rx_start      = rx_start_q;
    assign rx_end        = rx_end_q;
    assign rx_error      = rx_error_q;
    assign rx_length     = rx_length_q;
    assign rx_type       = rx_type_q;
    assign rx_node       = rx_node_q;
    assign payload_first = active && (pos_q == 16'd0);
    assign payload_last  = active && s_rx_last;
    assign payload_pos   = pos_q;
    assign payload_data  = s_rx_data;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_jellyvl_etherneco_slave_router.sv
// Bench for jellyvl_etherneco_slave_router: an upstream (node+1) and a downstream
// (node-1) instance share one stimulus; expectations come from a frame-level model.
module tb_jellyvl_etherneco_slave_router;

    localparam int          FN   = 2;
    localparam logic [7:0]  TB   = 8'h10;
    localparam logic [15:0] MAXL = 16'd1500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT signals ----------------
    logic            s_rx_first, s_rx_last, s_rx_valid;
    logic [7:0]      s_rx_data;
    logic [FN-1:0]   replace_valid;
    logic [8*FN-1:0] replace_data;

    logic m_tx_first, m_tx_last, m_tx_valid;
    logic [7:0] m_tx_data;
    logic rx_start, rx_end, rx_error;
    logic [15:0] rx_length;
    logic [7:0] rx_type, rx_node;
    logic payload_first, payload_last;
    logic [15:0] payload_pos;
    logic [7:0] payload_data;
    logic [FN-1:0] payload_valid;
    logic [1:0] dbg_state;

    logic dn_first, dn_last, dn_valid;
    logic [7:0] dn_data;
    logic dn_start, dn_end, dn_error;
    logic [15:0] dn_length;
    logic [7:0] dn_type, dn_node;
    logic dn_pfirst, dn_plast;
    logic [15:0] dn_pos;
    logic [7:0] dn_pdata;
    logic [FN-1:0] dn_pvalid;
    logic [1:0] dn_state;

    jellyvl_etherneco_slave_router #(
        .FUNC_NUM (FN), .TYPE_BASE (TB), .DOWN_STREAM (1'b0), .MAX_LENGTH (MAXL)
    ) dut (
        .clk (clk), .reset (reset),
        .s_rx_first (s_rx_first), .s_rx_last (s_rx_last), .s_rx_valid (s_rx_valid), .s_rx_data (s_rx_data),
        .m_tx_first (m_tx_first), .m_tx_last (m_tx_last), .m_tx_valid (m_tx_valid), .m_tx_data (m_tx_data),
        .rx_start (rx_start), .rx_end (rx_end), .rx_error (rx_error),
        .rx_length (rx_length), .rx_type (rx_type), .rx_node (rx_node),
        .payload_first (payload_first), .payload_last (payload_last), .payload_pos (payload_pos),
        .payload_data (payload_data), .payload_valid (payload_valid),
        .replace_data (replace_data), .replace_valid (replace_valid),
        .dbg_state_o (dbg_state)
    );

    jellyvl_etherneco_slave_router #(
        .FUNC_NUM (FN), .TYPE_BASE (TB), .DOWN_STREAM (1'b1), .MAX_LENGTH (MAXL)
    ) dut_dn (
        .clk (clk), .reset (reset),
        .s_rx_first (s_rx_first), .s_rx_last (s_rx_last), .s_rx_valid (s_rx_valid), .s_rx_data (s_rx_data),
        .m_tx_first (dn_first), .m_tx_last (dn_last), .m_tx_valid (dn_valid), .m_tx_data (dn_data),
        .rx_start (dn_start), .rx_end (dn_end), .rx_error (dn_error),
        .rx_length (dn_length), .rx_type (dn_type), .rx_node (dn_node),
        .payload_first (dn_pfirst), .payload_last (dn_plast), .payload_pos (dn_pos),
        .payload_data (dn_pdata), .payload_valid (dn_pvalid),
        .replace_data (replace_data), .replace_valid (replace_valid),
        .dbg_state_o (dn_state)
    );

    // ---------------- scoreboard state ----------------
    int n_vec;
    int n_err;
    bit open_in_frame;   // previous frame stopped without last while still in header/payload

    logic        pend_v, pend_f, pend_l, pend_st, pend_en, pend_er;
    logic [7:0]  pend_d, pend_d_dn;
    logic [15:0] pend_len;
    logic [7:0]  pend_type, pend_node;
    logic [15:0] cur_len;
    logic [7:0]  cur_type, cur_node;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_pend();
        pend_v = 1'b0; pend_f = 1'b0; pend_l = 1'b0;
        pend_st = 1'b0; pend_en = 1'b0; pend_er = 1'b0;
        pend_d = 8'h00; pend_d_dn = 8'h00;
        pend_len = 16'h0; pend_type = 8'h00; pend_node = 8'h00;
    endtask

    // Registered outputs produced by the byte of the previous step.
    task automatic check_prev();
        if (pend_st) begin
            cur_len  = pend_len;
            cur_type = pend_type;
            cur_node = pend_node;
        end
        check("m_tx_valid", 32'(m_tx_valid), 32'(pend_v));
        check("dn_tx_valid", 32'(dn_valid), 32'(pend_v));
        if (pend_v) begin
            check("m_tx_first", 32'(m_tx_first), 32'(pend_f));
            check("m_tx_last", 32'(m_tx_last), 32'(pend_l));
            check("m_tx_data", 32'(m_tx_data), 32'(pend_d));
            check("dn_tx_data", 32'(dn_data), 32'(pend_d_dn));
        end
        check("rx_start", 32'(rx_start), 32'(pend_st));
        check("rx_end", 32'(rx_end), 32'(pend_en));
        check("rx_error", 32'(rx_error), 32'(pend_er));
        check("dn_rx_error", 32'(dn_error), 32'(pend_er));
        check("rx_length", 32'(rx_length), 32'(cur_len));
        check("rx_type", 32'(rx_type), 32'(cur_type));
        check("rx_node", 32'(rx_node), 32'(cur_node));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic f, input logic l, input logic [7:0] d,
                        input logic [FN-1:0] rv, input logic [8*FN-1:0] rd,
                        input logic act, input logic [FN-1:0] e_pv, input logic [15:0] e_pos,
                        input logic [7:0] e_tx, input logic [7:0] e_tx_dn,
                        input logic e_st, input logic e_en, input logic e_er,
                        input logic [15:0] h_len, input logic [7:0] h_type, input logic [7:0] h_node);
        s_rx_valid = v; s_rx_first = f; s_rx_last = l; s_rx_data = d;
        replace_valid = rv; replace_data = rd;
        @(negedge clk);
        check_prev();
        check("payload_valid", 32'(payload_valid), 32'(e_pv));
        check("dn_payload_valid", 32'(dn_pvalid), 32'(e_pv));
        if (act) begin
            check("payload_pos", 32'(payload_pos), 32'(e_pos));
            check("payload_data", 32'(payload_data), 32'(d));
            check("payload_first", 32'(payload_first), 32'(e_pos == 16'd0));
            check("payload_last", 32'(payload_last), 32'(l));
        end
        pend_v = v; pend_f = f; pend_l = l; pend_d = e_tx; pend_d_dn = e_tx_dn;
        pend_st = e_st; pend_en = e_en; pend_er = e_er;
        pend_len = h_len; pend_type = h_type; pend_node = h_node;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            step(1'b0, 1'b0, 1'b0, 8'($urandom), FN'($urandom), (8*FN)'($urandom), 1'b0, '0, 16'h0,
                 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'h00);
        end
    endtask

    // Asynchronous reset in the middle of traffic: outputs must clear at once.
    task automatic mid_reset();
        s_rx_valid = 1'b0; s_rx_first = 1'b0; s_rx_last = 1'b0; replace_valid = '0;
        reset = 1'b0;
        #1;
        check("rst_m_tx_valid", 32'(m_tx_valid), 32'h0);
        check("rst_m_tx_data", 32'(m_tx_data), 32'h0);
        check("rst_rx_start", 32'(rx_start), 32'h0);
        check("rst_rx_end", 32'(rx_end), 32'h0);
        check("rst_rx_error", 32'(rx_error), 32'h0);
        check("rst_rx_length", 32'(rx_length), 32'h0);
        check("rst_rx_type", 32'(rx_type), 32'h0);
        check("rst_rx_node", 32'(rx_node), 32'h0);
        check("rst_payload_valid", 32'(payload_valid), 32'h0);
        clear_pend();
        cur_len = 16'h0; cur_type = 8'h00; cur_node = 8'h00;
        open_in_frame = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame of n bytes (header + payload) and predicts every output
    // from the frame rules. repl_mode: 0 none, 1 random, 2 ch0=AA at pos 2.
    task automatic send_frame(input int n, input logic [15:0] len, input logic [7:0] typ,
                              input logic [7:0] node, input bit trunc, input int repl_mode,
                              input bit seq, input bit gaps, input int rst_at);
        logic [7:0] sel, d, e_tx, e_tx_dn;
        logic [FN-1:0] e_pv, rv;
        logic [8*FN-1:0] rd;
        bit in_rng, ok_len, is_last, in_pay, st, en, er;
        int p, len_i;
        sel    = typ - TB;
        in_rng = (sel < 8'(FN));
        ok_len = (len <= MAXL);
        len_i  = int'(len);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            p       = i - 4;
            is_last = (i == n - 1) && !trunc;
            in_pay  = ok_len && (i >= 4) && (p <= len_i);
            case (i)
                0:       d = len[7:0];
                1:       d = len[15:8];
                2:       d = typ;
                3:       d = node;
                default: d = seq ? 8'(p + 1) : 8'($urandom);
            endcase
            rd = (8*FN)'($urandom);
            case (repl_mode)
                1:       rv = FN'($urandom);
                2:       begin rv = (p == 2) ? FN'(1) : '0; rd[7:0] = 8'hAA; end
                default: rv = '0;
            endcase
            for (int c = 0; c < FN; c++) e_pv[c] = in_pay && in_rng && (sel == 8'(c));
            e_tx = d;
            for (int c = 0; c < FN; c++) if (e_pv[c] && rv[c]) e_tx = rd[8*c +: 8];
            e_tx_dn = e_tx;
            if (i == 3) begin
                e_tx    = node + 8'd1;
                e_tx_dn = node - 8'd1;
            end
            st = (i == 3) && !is_last;
            en = in_pay && is_last && (p == len_i);
            er = (is_last && (i <= 3))
                 || (st && !ok_len)
                 || (in_pay && is_last && (p < len_i))
                 || (in_pay && !is_last && (p == len_i))
                 || ((i == 0) && open_in_frame);
            step(1'b1, i == 0, is_last, d, rv, rd, in_pay, e_pv, 16'(p), e_tx, e_tx_dn,
                 st, en, er, len, typ, node);
        end
        open_in_frame = trunc && ((n < 4) || (ok_len && (n - 4 <= len_i)));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] r_len;
        int          r_n;
        int          r_sel;
        bit          r_trunc;

        n_vec = 0;
        n_err = 0;
        open_in_frame = 1'b0;
        clear_pend();
        cur_len = 16'h0; cur_type = 8'h00; cur_node = 8'h00;
        s_rx_valid = 1'b0; s_rx_first = 1'b0; s_rx_last = 1'b0; s_rx_data = 8'h00;
        replace_valid = '0; replace_data = '0;
        reset = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_m_tx_valid", 32'(m_tx_valid), 32'h0);
        check("reset_m_tx_data", 32'(m_tx_data), 32'h0);
        check("reset_rx_start", 32'(rx_start), 32'h0);
        check("reset_rx_error", 32'(rx_error), 32'h0);
        check("reset_rx_length", 32'(rx_length), 32'h0);
        check("reset_payload_valid", 32'(payload_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Length 3, type 11, node 5, payload 1..4: clean pass-through, channel 1.
        send_frame(8, 16'd3, 8'h11, 8'h05, 1'b0, 0, 1'b1, 1'b0, -1);
        // Channel 0 replaces the third payload byte with AA.
        send_frame(8, 16'd3, 8'h10, 8'h20, 1'b0, 2, 1'b1, 1'b0, -1);
        // Last arrives on the third payload byte of a length-3 frame.
        send_frame(7, 16'd3, 8'h11, 8'h07, 1'b0, 0, 1'b1, 1'b0, -1);
        // Oversize length: drained, no payload strobes even with replace requests.
        send_frame(14, 16'd2000, 8'h11, 8'h09, 1'b0, 1, 1'b0, 1'b0, -1);
        send_frame(8, 16'd3, 8'h10, 8'h0A, 1'b0, 1, 1'b0, 1'b1, -1);
        // Node wrap and an out-of-range type.
        send_frame(8, 16'd3, 8'h30, 8'h00, 1'b0, 1, 1'b0, 1'b0, -1);
        // Late last, node FF wraps upward.
        send_frame(10, 16'd2, 8'h11, 8'hFF, 1'b0, 0, 1'b0, 1'b0, -1);
        // A new first inside the header, then inside the payload.
        send_frame(3, 16'd0, 8'h10, 8'h01, 1'b1, 0, 1'b0, 1'b0, -1);
        send_frame(9, 16'd4, 8'h11, 8'h02, 1'b1, 0, 1'b0, 1'b0, 6);
        send_frame(9, 16'd4, 8'h11, 8'h02, 1'b0, 1, 1'b0, 1'b0, -1);
        send_frame(6, 16'd5, 8'h10, 8'h03, 1'b1, 0, 1'b0, 1'b0, -1);
        send_frame(5, 16'd0, 8'h10, 8'h04, 1'b0, 1, 1'b0, 1'b0, -1);
        // Largest legal length, then one past it.
        send_frame(1505, MAXL, 8'h10, 8'h40, 1'b0, 1, 1'b0, 1'b0, -1);
        send_frame(8, MAXL + 16'd1, 8'h10, 8'h41, 1'b0, 0, 1'b0, 1'b0, -1);
        // Reset mid-payload, quiet afterwards, next frame completes.
        send_frame(9, 16'd4, 8'h11, 8'h33, 1'b0, 1, 1'b0, 1'b0, 6);
        idle(3);
        send_frame(9, 16'd4, 8'h11, 8'h34, 1'b0, 1, 1'b0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            r_len   = 16'($urandom_range(0, 12));
            r_trunc = 1'b0;
            r_sel   = $urandom_range(0, 9);
            if (r_sel == 9) begin
                r_len = MAXL + 16'($urandom_range(1, 3));
                r_n   = $urandom_range(5, 12);
            end else if (r_sel == 8) begin
                r_trunc = 1'b1;
                r_n     = $urandom_range(2, int'(r_len) + 5);
            end else if (r_sel == 7) begin
                r_n = int'(r_len) + 6;
            end else if (r_sel == 6) begin
                r_n = int'(r_len) + 4;
            end else begin
                r_n = int'(r_len) + 5;
            end
            send_frame(r_n, r_len, 8'($urandom_range(8'h0E, 8'h13)), 8'($urandom), r_trunc, 1,
                       1'b0, 1'($urandom_range(0, 1)), -1);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jellyvl_etherneco_slave_router.md
JELLYVL_ETHERNECO_SLAVE_ROUTER -- requirements
Module: jellyvl_etherneco_slave_router

Interface
REQ-001 SHALL have parameter FUNC_NUM, default 2, number of function channels (1..8).
REQ-002 SHALL have parameter TYPE_BASE, default 8'h10; type TYPE_BASE+i selects channel i.
REQ-003 SHALL have parameter DOWN_STREAM, default 1'b0; 0 forwards node+1, 1 forwards node-1.
REQ-004 SHALL have parameter MAX_LENGTH, default 16'd1500, largest legal length field.
REQ-005 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have ports: s_rx_first/s_rx_last/s_rx_valid in 1, s_rx_data in 8, upstream byte stream with no backpressure.
REQ-007 SHALL have ports: m_tx_first/m_tx_last/m_tx_valid out 1, m_tx_data out 8, forwarded stream.
REQ-008 SHALL have ports: rx_start/rx_end/rx_error out 1, pulses; rx_length out 16, rx_type out 8, rx_node out 8, received header.
REQ-009 SHALL have ports: payload_first/payload_last out 1, payload_pos out 16, payload_data out 8, payload_valid out FUNC_NUM, one-hot per channel.
REQ-010 SHALL have ports: replace_data in 8*FUNC_NUM, replace_valid in FUNC_NUM, per-channel substitution.

Function
REQ-011 Frame SHALL be header [len_lo, len_hi, type, node] then length+1 payload bytes; first on len_lo, last on final payload byte.
REQ-012 FSM SHALL have states IDLE, HEADER, PAYLOAD, DRAIN; IDLE->HEADER on valid&first, HEADER->PAYLOAD after node byte, PAYLOAD->IDLE on last, DRAIN->IDLE on valid&last.
REQ-013 m_tx_* SHALL equal s_rx_* delayed exactly one clk, byte for byte, except for node and replaced bytes.
REQ-014 Forwarded node byte SHALL be node+1 (DOWN_STREAM=0) or node-1 (DOWN_STREAM=1), modulo 256.
REQ-015 rx_start SHALL pulse one cycle after node byte accepted; rx_length/type/node SHALL update at that edge and hold until next rx_start.
REQ-016 payload_* SHALL be combinational from s_rx_* during PAYLOAD; only bit (type-TYPE_BASE) of payload_valid set; none if type out of range.
REQ-017 payload_pos SHALL be 0 on first payload byte, incrementing by 1 per accepted byte.
REQ-018 When selected channel's replace_valid is high with payload_valid, m_tx_data SHALL carry its replace_data next cycle.
REQ-019 rx_end SHALL pulse one cycle after last, when received payload count equals length+1.
REQ-020 rx_error SHALL pulse (instead of rx_end) on: last early or late; first inside a frame; length>MAX_LENGTH (then DRAIN, no payload_valid).
REQ-021 first inside a frame SHALL abort current frame and restart HEADER with the new byte in the same cycle.
REQ-022 Bytes with valid low SHALL not advance FSM or counters; m_tx_valid low that cycle.

Reset
REQ-023 During reset SHALL force state IDLE, all pulses and m_tx_valid 0, m_tx_data 0, rx_length/type/node 0, counters 0.
REQ-024 Reset mid-frame SHALL discard the frame; no rx_end or rx_error after release until a new first.

Configuration
REQ-025 Macro JELLYVL_ETHERNECO_ROUTER_STATS_EN SHALL add outputs stat_frames, stat_errors (32 bit, saturating), counting rx_end and rx_error pulses.
REQ-026 Without the macro, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-027 jellyvl_etherneco_pkg SHALL hold header offsets, header length 4, and the FSM state enum.
REQ-028 Sub-module jellyvl_etherneco_func_mux SHALL implement channel decode, payload_valid fan-out and replace selection.

Verification
REQ-029 Length 3, type 8'h11, node 5, payload 1..4, no replace -> identical stream 1 clk later with node 6; rx_start, rx_end once; payload_valid=2'b10.
REQ-030 Type 8'h10, replace_valid[0] at pos 2 with 8'hAA -> only 3rd payload byte out is 8'hAA.
REQ-031 Length 3, last on 3rd payload byte -> rx_error pulse, no rx_end.
REQ-032 Length 16'd2000 -> rx_error, no payload_valid, frame forwarded unmodified except node; next frame normal.
REQ-033 DOWN_STREAM=1, node 8'h00 -> forwarded node 8'hFF; type 8'h30 -> payload_valid stays 0.
REQ-034 Reset asserted mid-payload -> outputs 0 immediately; next full frame after release yields rx_end.
